// File: rtl/axi_rd_arbiter_if.sv
// ---------------------------------------------------------------------------
// axi_rd_arbiter_if
// One AXI read-channel port (AR + R). The same interface type serves both
// master-side ports (ID_W wide IDs) and the slave-side port, which carries
// the master tag in the upper ID bits and so is instantiated with ID_W+4.
//   master modport : drives AR request and RREADY, receives ARREADY and R beat
//   slave  modport : receives AR request and RREADY, drives ARREADY and R beat
// ---------------------------------------------------------------------------
interface axi_rd_arbiter_if #(
   parameter int ID_W   = 4,
   parameter int ADDR_W = 32,
   parameter int LEN_W  = 4,
   parameter int DATA_W = 32
);
   logic [ID_W-1:0]   arid;
   logic [ADDR_W-1:0] araddr;
   logic [LEN_W-1:0]  arlen;
   logic [2:0]        arsize;
   logic [1:0]        arburst;
   logic              arvalid;
   logic              arready;
   logic [ID_W-1:0]   rid;
   logic [DATA_W-1:0] rdata;
   logic [1:0]        rresp;
   logic              rlast;
   logic              rvalid;
   logic              rready;

   modport master (
      output arid, araddr, arlen, arsize, arburst, arvalid, rready,
      input  arready, rid, rdata, rresp, rlast, rvalid
   );

   modport slave (
      input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
      output arready, rid, rdata, rresp, rlast, rvalid
   );
endinterface

// File: rtl/axi_rd_arbiter.sv
// ---------------------------------------------------------------------------
// axi_rd_arbiter
// Two-master AXI read arbiter in front of a single slave port.
// M0 (instruction side) and M1 (data side) compete for the slave; the winner's
// AR request is forwarded with ID {4'(grant), ARID}, and the R beats are routed
// back to it. The grant is held until the RLAST beat handshakes, after which
// one IDLE cycle separates bursts. Simultaneous requests alternate, starting
// with M0 after reset.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   m0, m1    : master-side read ports (slave modport, ID_W-bit IDs)
//   s         : slave-side read port (master modport, ID_W+4-bit IDs)
//   len_err   : sticky flag, set when RLAST position disagrees with ARLEN
// ---------------------------------------------------------------------------
module axi_rd_arbiter #(
   parameter int ID_W   = 4,
   parameter int ADDR_W = 32,
   parameter int LEN_W  = 4,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   axi_rd_arbiter_if.slave     m0,
   axi_rd_arbiter_if.slave     m1,
   axi_rd_arbiter_if.master    s,
   output logic                len_err
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2
   } state_t;

   state_t            state_r, state_nxt_s;
   logic              grant_r, grant_nxt_s;
   logic              last_grant_r, last_grant_nxt_s;
   logic [LEN_W-1:0]  beat_cnt_r, beat_cnt_nxt_s;
   logic [LEN_W-1:0]  len_q_r, len_q_nxt_s;
   logic              len_err_r, len_err_nxt_s;

   // request fields of the currently granted master
   logic [ID_W-1:0]   arid_g_s;
   logic [ADDR_W-1:0] araddr_g_s;
   logic [LEN_W-1:0]  arlen_g_s;
   logic [2:0]        arsize_g_s;
   logic [1:0]        arburst_g_s;
   logic              arvalid_g_s;
   logic              rready_g_s;
   logic [DATA_W-1:0] rdata_s;

   // Select the granted master's AR fields and RREADY.
   always_comb begin
      rdata_s = s.rdata;
      if (grant_r == 1'b1) begin
         arid_g_s    = m1.arid;
         araddr_g_s  = m1.araddr;
         arlen_g_s   = m1.arlen;
         arsize_g_s  = m1.arsize;
         arburst_g_s = m1.arburst;
         arvalid_g_s = m1.arvalid;
         rready_g_s  = m1.rready;
      end else begin
         arid_g_s    = m0.arid;
         araddr_g_s  = m0.araddr;
         arlen_g_s   = m0.arlen;
         arsize_g_s  = m0.arsize;
         arburst_g_s = m0.arburst;
         arvalid_g_s = m0.arvalid;
         rready_g_s  = m0.rready;
      end
   end

   // Next-state and output decode; everything idles at zero, and all outputs
   // are forced low while rst is asserted so nothing leaks before the edge.
   always_comb begin
      state_nxt_s      = state_r;
      grant_nxt_s      = grant_r;
      last_grant_nxt_s = last_grant_r;
      beat_cnt_nxt_s   = beat_cnt_r;
      len_q_nxt_s      = len_q_r;
      len_err_nxt_s    = len_err_r;

      s.arid    = {(ID_W+4){1'b0}};
      s.araddr  = {ADDR_W{1'b0}};
      s.arlen   = {LEN_W{1'b0}};
      s.arsize  = 3'b000;
      s.arburst = 2'b00;
      s.arvalid = 1'b0;
      s.rready  = 1'b0;
      m0.arready = 1'b0;
      m0.rid     = {ID_W{1'b0}};
      m0.rdata   = {DATA_W{1'b0}};
      m0.rresp   = 2'b00;
      m0.rlast   = 1'b0;
      m0.rvalid  = 1'b0;
      m1.arready = 1'b0;
      m1.rid     = {ID_W{1'b0}};
      m1.rdata   = {DATA_W{1'b0}};
      m1.rresp   = 2'b00;
      m1.rlast   = 1'b0;
      m1.rvalid  = 1'b0;

      if (rst == 1'b0) begin
         case (state_r)
            ST_IDLE: begin
               if (m0.arvalid && m1.arvalid) begin
                  grant_nxt_s = ~last_grant_r;
                  state_nxt_s = ST_ADDR;
               end else if (m0.arvalid) begin
                  grant_nxt_s = 1'b0;
                  state_nxt_s = ST_ADDR;
               end else if (m1.arvalid) begin
                  grant_nxt_s = 1'b1;
                  state_nxt_s = ST_ADDR;
               end else begin
                  state_nxt_s = ST_IDLE;
               end
            end

            ST_ADDR: begin
               s.arid    = {3'b000, grant_r, arid_g_s};
               s.araddr  = araddr_g_s;
               s.arlen   = arlen_g_s;
               s.arsize  = arsize_g_s;
               s.arburst = arburst_g_s;
               s.arvalid = arvalid_g_s;
               if (grant_r == 1'b1) begin
                  m1.arready = s.arready;
               end else begin
                  m0.arready = s.arready;
               end
               if (arvalid_g_s && s.arready) begin
                  len_q_nxt_s      = arlen_g_s;
                  beat_cnt_nxt_s   = {LEN_W{1'b0}};
                  last_grant_nxt_s = grant_r;
                  state_nxt_s      = ST_DATA;
               end else begin
                  state_nxt_s = ST_ADDR;
               end
            end

            ST_DATA: begin
               s.rready = rready_g_s;
               if (grant_r == 1'b1) begin
                  m1.rvalid = s.rvalid;
                  m1.rid    = s.rid[ID_W-1:0];
                  m1.rdata  = rdata_s;
                  m1.rresp  = s.rresp;
                  m1.rlast  = s.rlast;
               end else begin
                  m0.rvalid = s.rvalid;
                  m0.rid    = s.rid[ID_W-1:0];
                  m0.rdata  = rdata_s;
                  m0.rresp  = s.rresp;
                  m0.rlast  = s.rlast;
               end
               if (s.rvalid && rready_g_s) begin
                  beat_cnt_nxt_s = beat_cnt_r + LEN_W'(1);
                  if (s.rlast) begin
                     state_nxt_s = ST_IDLE;
                     if (beat_cnt_r != len_q_r) begin
                        len_err_nxt_s = 1'b1;
                     end else begin
                        len_err_nxt_s = len_err_r;
                     end
                  end else if (beat_cnt_r == len_q_r) begin
                     // slave overran ARLEN: flag it, keep routing until RLAST
                     len_err_nxt_s = 1'b1;
                  end else begin
                     state_nxt_s = ST_DATA;
                  end
               end else begin
                  state_nxt_s = ST_DATA;
               end
            end

            default: begin
               state_nxt_s = ST_IDLE;
            end
         endcase
      end else begin
         state_nxt_s = ST_IDLE;
      end
   end

   // State and bookkeeping registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= ST_IDLE;
         grant_r      <= 1'b0;
         last_grant_r <= 1'b1;
         beat_cnt_r   <= {LEN_W{1'b0}};
         len_q_r      <= {LEN_W{1'b0}};
         len_err_r    <= 1'b0;
      end else begin
         state_r      <= state_nxt_s;
         grant_r      <= grant_nxt_s;
         last_grant_r <= last_grant_nxt_s;
         beat_cnt_r   <= beat_cnt_nxt_s;
         len_q_r      <= len_q_nxt_s;
         len_err_r    <= len_err_nxt_s;
      end
   end

   assign len_err = len_err_r;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axi_rd_arbiter
// Directed bench for the two-master read arbiter. The bench acts as both
// masters and as the slave; each scenario task drives its own vectors and
// compares against hand-computed values.
// ---------------------------------------------------------------------------
module tb_axi_rd_arbiter;

   logic clk = 1'b0;
   logic rst;
   logic len_err;
   int   checks = 0;
   int   errors = 0;

   axi_rd_arbiter_if #(.ID_W(4), .ADDR_W(32), .LEN_W(4), .DATA_W(32)) mi0 ();
   axi_rd_arbiter_if #(.ID_W(4), .ADDR_W(32), .LEN_W(4), .DATA_W(32)) mi1 ();
   axi_rd_arbiter_if #(.ID_W(8), .ADDR_W(32), .LEN_W(4), .DATA_W(32)) si ();

   axi_rd_arbiter #(.ID_W(4), .ADDR_W(32), .LEN_W(4), .DATA_W(32)) dut (
      .clk     (clk),
      .rst     (rst),
      .m0      (mi0),
      .m1      (mi1),
      .s       (si),
      .len_err (len_err)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      mi0.arid = 4'h0; mi0.araddr = 32'h0; mi0.arlen = 4'h0; mi0.arsize = 3'd0;
      mi0.arburst = 2'b00; mi0.arvalid = 1'b0; mi0.rready = 1'b0;
      mi1.arid = 4'h0; mi1.araddr = 32'h0; mi1.arlen = 4'h0; mi1.arsize = 3'd0;
      mi1.arburst = 2'b00; mi1.arvalid = 1'b0; mi1.rready = 1'b0;
      si.arready = 1'b0; si.rid = 8'h00; si.rdata = 32'h0; si.rresp = 2'b00;
      si.rlast = 1'b0; si.rvalid = 1'b0;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      clear_inputs();
      cyc();
      cyc();
      rst = 1'b0;
   endtask

   // Wait (bounded) for ARVALID_S, accept it for one cycle; waited = -1 on timeout.
   task automatic wait_slave_ar(output logic [7:0] id, output int waited);
      waited = -1;
      id = 8'h00;
      for (int i = 0; i < 8; i++) begin
         #1;
         if (si.arvalid === 1'b1) begin
            id = si.arid;
            waited = i;
            si.arready = 1'b1;
            cyc();
            si.arready = 1'b0;
            break;
         end
         cyc();
      end
   endtask

   // Present n slave beats (RLAST on beat index last_at); count what each master saw.
   task automatic send_beats(input int n, input int last_at,
                             output int got0, output int got1,
                             output int last0, output int last1);
      got0 = 0; got1 = 0; last0 = 0; last1 = 0;
      for (int b = 0; b < n; b++) begin
         si.rvalid = 1'b1;
         si.rlast  = (b == last_at);
         si.rdata  = 32'hD000_0000 + 32'(b);
         #1;
         if (mi0.rvalid === 1'b1 && si.rready === 1'b1) begin
            got0++;
            if (mi0.rlast === 1'b1) last0 = b + 1;
         end
         if (mi1.rvalid === 1'b1 && si.rready === 1'b1) begin
            got1++;
            if (mi1.rlast === 1'b1) last1 = b + 1;
         end
         cyc();
      end
      si.rvalid = 1'b0;
      si.rlast  = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      clear_inputs();
      mi0.arvalid = 1'b1;
      mi0.araddr  = 32'h1234_5678;
      mi0.rready  = 1'b1;
      si.rvalid   = 1'b1;
      si.arready  = 1'b1;
      cyc();
      cyc();
      #1;
      if (si.arvalid !== 1'b0) begin errors++; $display("FAIL reset_arvalid_s got %b exp 0", si.arvalid); end
      checks++;
      if (si.rready !== 1'b0) begin errors++; $display("FAIL reset_rready_s got %b exp 0", si.rready); end
      checks++;
      if (mi0.arready !== 1'b0 || mi0.rvalid !== 1'b0) begin
         errors++; $display("FAIL reset_m0_handshake got %b%b exp 00", mi0.arready, mi0.rvalid);
      end
      checks++;
      if (si.araddr !== 32'h0) begin errors++; $display("FAIL reset_araddr_s got %h exp 0", si.araddr); end
      checks++;
      if (len_err !== 1'b0) begin errors++; $display("FAIL reset_len_err got %b exp 0", len_err); end
      checks++;
      rst = 1'b0;
      clear_inputs();
      cyc();
   endtask

   task automatic test_single();
      apply_reset();
      mi0.arid = 4'h2; mi0.araddr = 32'h0000_1000; mi0.arlen = 4'd3;
      mi0.arsize = 3'd2; mi0.arburst = 2'b01; mi0.arvalid = 1'b1;
      #1;
      if (si.arvalid !== 1'b0) begin errors++; $display("FAIL single_arvalid_n got %b exp 0", si.arvalid); end
      checks++;
      cyc();
      #1;
      if (si.arvalid !== 1'b1) begin errors++; $display("FAIL single_arvalid_n1 got %b exp 1", si.arvalid); end
      checks++;
      if (si.arid !== 8'h02) begin errors++; $display("FAIL single_arid_s got %h exp 02", si.arid); end
      checks++;
      if (si.araddr !== 32'h0000_1000 || si.arlen !== 4'd3) begin
         errors++; $display("FAIL single_ar_fields got %h/%h exp 00001000/3", si.araddr, si.arlen);
      end
      checks++;
      si.arready = 1'b1;
      #1;
      if (mi0.arready !== 1'b1 || mi1.arready !== 1'b0) begin
         errors++; $display("FAIL single_arready got m0=%b m1=%b exp 1/0", mi0.arready, mi1.arready);
      end
      checks++;
      cyc();
      mi0.arvalid = 1'b0; si.arready = 1'b0;
      mi0.rready = 1'b1; mi1.rready = 1'b1;
      for (int b = 0; b < 4; b++) begin
         si.rvalid = 1'b1; si.rid = 8'h02; si.rresp = 2'b00;
         si.rdata = 32'hA5A5_0000 + 32'(b);
         si.rlast = (b == 3);
         #1;
         if (mi0.rvalid !== 1'b1 || si.rready !== 1'b1) begin
            errors++; $display("FAIL single_beat%0d_hs got rvalid=%b rready_s=%b exp 1/1", b, mi0.rvalid, si.rready);
         end
         checks++;
         if (mi0.rdata !== 32'hA5A5_0000 + 32'(b) || mi0.rid !== 4'h2) begin
            errors++; $display("FAIL single_beat%0d_data got %h/%h exp %h/2", b, mi0.rdata, mi0.rid, 32'hA5A5_0000 + 32'(b));
         end
         checks++;
         if (mi0.rlast !== (b == 3)) begin
            errors++; $display("FAIL single_beat%0d_rlast got %b exp %b", b, mi0.rlast, (b == 3));
         end
         checks++;
         if (mi1.rvalid !== 1'b0) begin errors++; $display("FAIL single_beat%0d_m1_rvalid got %b exp 0", b, mi1.rvalid); end
         checks++;
         cyc();
      end
      si.rvalid = 1'b0; si.rlast = 1'b0;
      #1;
      if (si.rready !== 1'b0 || mi0.rvalid !== 1'b0) begin
         errors++; $display("FAIL single_after_idle got rready_s=%b rvalid=%b exp 0/0", si.rready, mi0.rvalid);
      end
      checks++;
      if (len_err !== 1'b0) begin errors++; $display("FAIL single_len_err got %b exp 0", len_err); end
      checks++;
      clear_inputs();
      cyc();
   endtask

   task automatic test_tie();
      logic [7:0] id;
      int w, g0, g1, l0, l1;
      apply_reset();
      mi0.arid = 4'h5; mi0.arlen = 4'd1; mi0.arvalid = 1'b1; mi0.rready = 1'b1;
      mi1.arid = 4'h9; mi1.arlen = 4'd0; mi1.arvalid = 1'b1; mi1.rready = 1'b1;
      wait_slave_ar(id, w);
      mi0.arvalid = 1'b0;
      if (id !== 8'h05 || w !== 1) begin errors++; $display("FAIL tie_first got id=%h lat=%0d exp 05/1", id, w); end
      checks++;
      send_beats(2, 1, g0, g1, l0, l1);
      if (g0 !== 2 || g1 !== 0 || l0 !== 2) begin
         errors++; $display("FAIL tie_m0_beats got %0d/%0d last%0d exp 2/0 last2", g0, g1, l0);
      end
      checks++;
      wait_slave_ar(id, w);
      mi1.arvalid = 1'b0;
      if (id !== 8'h19 || w !== 1) begin errors++; $display("FAIL tie_second got id=%h lat=%0d exp 19/1", id, w); end
      checks++;
      send_beats(1, 0, g0, g1, l0, l1);
      if (g0 !== 0 || g1 !== 1 || l1 !== 1) begin
         errors++; $display("FAIL tie_m1_beats got %0d/%0d last%0d exp 0/1 last1", g0, g1, l1);
      end
      checks++;
      clear_inputs();
      cyc();
   endtask

   task automatic test_alternate();
      logic [7:0] id;
      logic [7:0] exp_id [4];
      int w, g0, g1, l0, l1;
      exp_id = '{8'h01, 8'h12, 8'h01, 8'h12};
      apply_reset();
      mi0.arid = 4'h1; mi0.arlen = 4'd0; mi0.arvalid = 1'b1; mi0.rready = 1'b1;
      mi1.arid = 4'h2; mi1.arlen = 4'd0; mi1.arvalid = 1'b1; mi1.rready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         wait_slave_ar(id, w);
         if (id !== exp_id[k] || w !== 1) begin
            errors++; $display("FAIL alt_grant%0d got id=%h lat=%0d exp %h/1", k, id, w, exp_id[k]);
         end
         checks++;
         send_beats(1, 0, g0, g1, l0, l1);
         if (g0 !== ((k % 2 == 0) ? 1 : 0) || g1 !== ((k % 2 == 0) ? 0 : 1)) begin
            errors++; $display("FAIL alt_route%0d got %0d/%0d exp %0d/%0d", k, g0, g1, (k % 2 == 0) ? 1 : 0, (k % 2 == 0) ? 0 : 1);
         end
         checks++;
      end
      clear_inputs();
      #1;
      if (len_err !== 1'b0) begin errors++; $display("FAIL alt_len_err got %b exp 0", len_err); end
      checks++;
      cyc();
   endtask

   task automatic test_rready_stall();
      logic [7:0] id;
      int w, g0, g1, l0, l1;
      apply_reset();
      mi0.arid = 4'h3; mi0.arlen = 4'd3; mi0.arvalid = 1'b1;
      wait_slave_ar(id, w);
      mi0.arvalid = 1'b0;
      mi0.rready = 1'b1;
      send_beats(1, 99, g0, g1, l0, l1);
      mi0.rready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         si.rvalid = 1'b1;
         #1;
         if (si.rready !== 1'b0 || mi0.rvalid !== 1'b1) begin
            errors++; $display("FAIL stall_cycle%0d got rready_s=%b rvalid=%b exp 0/1", c, si.rready, mi0.rvalid);
         end
         checks++;
         cyc();
      end
      mi0.rready = 1'b1;
      send_beats(3, 2, g0, g1, l0, l1);
      if (g0 !== 3 || l0 !== 3) begin errors++; $display("FAIL stall_rest got %0d last%0d exp 3 last3", g0, l0); end
      checks++;
      #1;
      if (len_err !== 1'b0 || si.rready !== 1'b0) begin
         errors++; $display("FAIL stall_end got len_err=%b rready_s=%b exp 0/0", len_err, si.rready);
      end
      checks++;
      clear_inputs();
      cyc();
   endtask

   task automatic test_len_err();
      logic [7:0] id;
      int w, g0, g1, l0, l1;
      apply_reset();
      mi0.arid = 4'h7; mi0.arlen = 4'd1; mi0.arvalid = 1'b1; mi0.rready = 1'b1;
      wait_slave_ar(id, w);
      mi0.arvalid = 1'b0;
      send_beats(1, 0, g0, g1, l0, l1);
      #1;
      if (len_err !== 1'b1 || g0 !== 1) begin
         errors++; $display("FAIL short_len_err got err=%b beats=%0d exp 1/1", len_err, g0);
      end
      checks++;
      mi1.arid = 4'h4; mi1.arlen = 4'd0; mi1.arvalid = 1'b1; mi1.rready = 1'b1;
      wait_slave_ar(id, w);
      mi1.arvalid = 1'b0;
      if (id !== 8'h14 || w !== 1) begin errors++; $display("FAIL short_next_ar got id=%h lat=%0d exp 14/1", id, w); end
      checks++;
      send_beats(1, 0, g0, g1, l0, l1);
      #1;
      if (len_err !== 1'b1 || g1 !== 1) begin
         errors++; $display("FAIL short_sticky got err=%b beats=%0d exp 1/1", len_err, g1);
      end
      checks++;
      // overrun: ARLEN=0 but RLAST only on the second beat
      apply_reset();
      mi0.arid = 4'h6; mi0.arlen = 4'd0; mi0.arvalid = 1'b1; mi0.rready = 1'b1;
      wait_slave_ar(id, w);
      mi0.arvalid = 1'b0;
      #1;
      if (len_err !== 1'b0) begin errors++; $display("FAIL over_pre got %b exp 0", len_err); end
      checks++;
      send_beats(2, 1, g0, g1, l0, l1);
      #1;
      if (len_err !== 1'b1 || g0 !== 2 || si.rready !== 1'b0) begin
         errors++; $display("FAIL over_len_err got err=%b beats=%0d rready_s=%b exp 1/2/0", len_err, g0, si.rready);
      end
      checks++;
      clear_inputs();
      cyc();
   endtask

   task automatic test_rst_mid();
      logic [7:0] id;
      int w, g0, g1, l0, l1;
      apply_reset();
      mi0.arid = 4'h1; mi0.arlen = 4'd1; mi0.arvalid = 1'b1; mi0.rready = 1'b1;
      wait_slave_ar(id, w);
      mi0.arvalid = 1'b0;
      send_beats(1, 0, g0, g1, l0, l1);
      mi0.arlen = 4'd3; mi0.arvalid = 1'b1;
      wait_slave_ar(id, w);
      mi0.arvalid = 1'b0;
      send_beats(1, 99, g0, g1, l0, l1);
      #1;
      if (len_err !== 1'b1) begin errors++; $display("FAIL rstmid_pre_err got %b exp 1", len_err); end
      checks++;
      si.rvalid = 1'b1;
      rst = 1'b1;
      #1;
      if (si.rready !== 1'b0 || mi0.rvalid !== 1'b0) begin
         errors++; $display("FAIL rstmid_during got rready_s=%b rvalid=%b exp 0/0", si.rready, mi0.rvalid);
      end
      checks++;
      cyc();
      rst = 1'b0;
      #1;
      if (si.rready !== 1'b0 || mi0.rvalid !== 1'b0 || si.arvalid !== 1'b0 || mi0.arready !== 1'b0) begin
         errors++; $display("FAIL rstmid_after got rr=%b rv=%b av=%b ar=%b exp 0000", si.rready, mi0.rvalid, si.arvalid, mi0.arready);
      end
      checks++;
      if (len_err !== 1'b0) begin errors++; $display("FAIL rstmid_len_err got %b exp 0", len_err); end
      checks++;
      si.rvalid = 1'b0;
      mi1.arid = 4'h3; mi1.arlen = 4'd0; mi1.arvalid = 1'b1; mi1.rready = 1'b1;
      wait_slave_ar(id, w);
      mi1.arvalid = 1'b0;
      if (id !== 8'h13 || w !== 1) begin errors++; $display("FAIL rstmid_m1_ar got id=%h lat=%0d exp 13/1", id, w); end
      checks++;
      send_beats(1, 0, g0, g1, l0, l1);
      if (g1 !== 1 || g0 !== 0 || len_err !== 1'b0) begin
         errors++; $display("FAIL rstmid_m1_burst got %0d/%0d err=%b exp 0/1/0", g0, g1, len_err);
      end
      checks++;
      clear_inputs();
      cyc();
   endtask

   initial begin
      rst = 1'b1;
      clear_inputs();
      test_reset();
      test_single();
      test_tie();
      test_alternate();
      test_rready_stall();
      test_len_err();
      test_rst_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
